irq_ctrl_gen: RTL

- Parametrised successor of the sub-CPU interrupt controller: 68000 interrupt encoder with N_IRQ request channels.
- Per-channel edge/level mode, autovector or vectored acknowledge, software-set pending, sticky overrun flags and spurious-IACK detection.
- Sits between the ASIC interrupt sources (timer, CDD, CDC, graphics, sub-code) and the sub-CPU IPL/VPA/DTACK pins.
- Qualified by the sub_sync clock enable.

---
 rtl/irq_ctrl_gen_if.sv | 20 ++
 rtl/irq_ctrl_gen.sv | 139 +++++++++++++
 2 files changed

// File: rtl/irq_ctrl_gen_if.sv
// rtl/irq_ctrl_gen_if.sv - 68000 sub-CPU interrupt/IACK bus
interface irq_ctrl_gen_if;
    logic [2:0] cpu_fc;
    logic [3:1] cpu_addr;
    logic       cpu_oe;
    logic [2:0] cpu_ipl;
    logic       cpu_vpa;
    logic       cpu_dtack;
    logic [7:0] vec_out;

    modport master (
        output cpu_fc, cpu_addr, cpu_oe,
        input  cpu_ipl, cpu_vpa, cpu_dtack, vec_out
    );

    modport slave (
        input  cpu_fc, cpu_addr, cpu_oe,
        output cpu_ipl, cpu_vpa, cpu_dtack, vec_out
    );
endinterface

// File: rtl/irq_ctrl_gen.sv
// rtl/irq_ctrl_gen.sv - parametrised 68000 interrupt encoder with IACK handling
// Edge/level request channels, software pending, overrun flags, autovector or vectored acknowledge.
module irq_ctrl_gen #(
    parameter int         N_IRQ     = 6,
    parameter logic [6:0] EDGE_MASK = 7'h7F,
    parameter logic [6:0] VECT_MASK = 7'h00
) (
    input  logic             clk_asic,
    input  logic             rst,
    input  logic             sub_sync,
    input  logic [N_IRQ-1:0] ireq,
    input  logic [N_IRQ-1:0] imsk,
    input  logic [N_IRQ-1:0] swi_set,
    input  logic [N_IRQ-1:0] ovr_clr,
    input  logic [7:0]       vec_base,
    irq_ctrl_gen_if.slave    bus,
    output logic [N_IRQ-1:0] irq_pend_out,
    output logic [N_IRQ-1:0] irq_ovr,
    output logic             spurious
);

    typedef enum logic {S_IDLE, S_ACK} state_t;
    state_t state_q, state_d;

    logic [N_IRQ-1:0] hist0_q, hist1_q, pend_q, pend_d, ovr_q, ovr_d, swi_q, swi_d;
    logic [N_IRQ-1:0] req_on, edge_det, ack;
    logic [2:0]       ipl_q, ipl_d, top_lvl;
    logic             vpa_q, vpa_d, dtack_q, dtack_d, spur_q, spur_d;
    logic [7:0]       vec_q, vec_d;
    logic [7:0]       pend_by_lvl, vect_by_lvl;
    logic             cpu_space, l_pend, l_vect;
    logic [2:0]       lvl_a;

    // Per-channel request gating, pending and overrun next state
    always_comb begin
        req_on   = '0;
        edge_det = '0;
        pend_d   = '0;
        ovr_d    = '0;
        swi_d    = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            req_on[i]   = ireq[i] & (imsk[i] | (i == 6));
            edge_det[i] = hist0_q[i] & ~hist1_q[i];
            if (EDGE_MASK[i]) begin
                pend_d[i] = edge_det[i] | swi_set[i] | (pend_q[i] & ~ack[i]);
                ovr_d[i]  = (edge_det[i] & pend_q[i] & ~ack[i]) | (ovr_q[i] & ~ovr_clr[i]);
            end else begin
                swi_d[i]  = swi_set[i] | (swi_q[i] & ~ack[i]);
                pend_d[i] = hist0_q[i] | swi_d[i];
            end
        end
    end

    // Priority encode; bit 0 of the by-level vectors stands for "level 0", never pending
    always_comb begin
        top_lvl     = 3'd0;
        pend_by_lvl = '0;
        vect_by_lvl = {VECT_MASK, 1'b0};
        for (int i = 0; i < N_IRQ; i++) begin
            pend_by_lvl[i+1] = pend_q[i];
            if (pend_q[i]) top_lvl = 3'(i + 1);
        end
        ipl_d = ~top_lvl;
    end

    assign lvl_a     = bus.cpu_addr;
    assign cpu_space = ~bus.cpu_oe & (bus.cpu_fc == 3'b111);
    assign l_pend    = pend_by_lvl[lvl_a];
    assign l_vect    = l_pend & vect_by_lvl[lvl_a];

    always_comb begin
        state_d = state_q;
        ack     = '0;
        vpa_d   = vpa_q;
        dtack_d = dtack_q;
        vec_d   = vec_q;
        spur_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_space) begin
                    state_d = S_ACK;
                    spur_d  = ~l_pend;
                    for (int i = 0; i < N_IRQ; i++) ack[i] = (lvl_a == 3'(i + 1));
                    if (l_vect) begin
                        dtack_d = 1'b0;
                        vec_d   = vec_base + {5'b0, lvl_a};
                    end else begin
                        vpa_d = 1'b0;
                    end
                end
            end
            S_ACK: begin
                if (!cpu_space) begin
                    state_d = S_IDLE;
                    vpa_d   = 1'b1;
                    dtack_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(negedge clk_asic or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            hist0_q <= '0;
            hist1_q <= '0;
            pend_q  <= '0;
            ovr_q   <= '0;
            swi_q   <= '0;
            ipl_q   <= 3'b111;
            vpa_q   <= 1'b1;
            dtack_q <= 1'b1;
            vec_q   <= 8'h00;
            spur_q  <= 1'b0;
        end else if (sub_sync) begin
            state_q <= state_d;
            hist0_q <= req_on;
            hist1_q <= hist0_q;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            swi_q   <= swi_d;
            ipl_q   <= ipl_d;
            vpa_q   <= vpa_d;
            dtack_q <= dtack_d;
            vec_q   <= vec_d;
            spur_q  <= spur_d;
        end
    end

    assign bus.cpu_ipl   = ipl_q;
    assign bus.cpu_vpa   = vpa_q;
    assign bus.cpu_dtack = dtack_q;
    assign bus.vec_out   = vec_q;
    assign irq_pend_out  = pend_q;
    assign irq_ovr       = ovr_q;
    assign spurious      = spur_q;

endmodule
